// File: rtl/axis_gate_sequencer_pkg.sv
// axis_gate_sequencer_pkg: gate descriptor layout, sequencer states and descriptor packing shared with the gate controller
package axis_gate_sequencer_pkg;
  localparam int GATE_FIELD_WIDTH = 32;
  localparam int GATE_DESC_WIDTH = 128;
  localparam int GATE_ON_LSB = 0;
  localparam int GATE_OFF_LSB = 32;
  localparam int GATE_PER_LSB = 64;
  localparam int GATE_POFF_LSB = 96;
  typedef enum logic {IDLE, SEND} gate_state_t;
  function automatic logic [GATE_DESC_WIDTH-1:0] gate_desc(
    input logic [GATE_FIELD_WIDTH-1:0] g_on,
    input logic [GATE_FIELD_WIDTH-1:0] g_off,
    input logic [GATE_FIELD_WIDTH-1:0] g_per,
    input logic [GATE_FIELD_WIDTH-1:0] g_poff
  );
    logic [GATE_DESC_WIDTH-1:0] d;
    d = '0;
    d[GATE_ON_LSB +: GATE_FIELD_WIDTH] = g_on;
    d[GATE_OFF_LSB +: GATE_FIELD_WIDTH] = g_off;
    d[GATE_PER_LSB +: GATE_FIELD_WIDTH] = g_per;
    d[GATE_POFF_LSB +: GATE_FIELD_WIDTH] = g_poff;
    return d;
  endfunction
endpackage

// File: rtl/axis_gate_sequencer_edge_detector.sv
// axis_gate_sequencer_edge_detector: registered rising-edge detect; a level already high when reset releases is not an edge
module axis_gate_sequencer_edge_detector (
  input  logic aclk,
  input  logic aresetn,
  input  logic sig,
  output logic rise
);
  logic sig_q;
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) begin
      sig_q <= 1'b1;
      rise <= 1'b0;
    end else begin
      sig_q <= sig;
      rise <= sig & ~sig_q;
    end
endmodule

// File: rtl/axis_gate_sequencer.sv
// axis_gate_sequencer: AXI4-Stream master emitting a trigger-started train of 128-bit gate descriptors with advancing phase offset
module axis_gate_sequencer
  import axis_gate_sequencer_pkg::*;
#(
  parameter int CNTR_WIDTH = 32
) (
  input  logic                       aclk,
  input  logic                       aresetn,
  input  logic [31:0]                cfg_on,
  input  logic [31:0]                cfg_off,
  input  logic [31:0]                cfg_period,
  input  logic [31:0]                cfg_poff,
  input  logic [31:0]                cfg_step,
  input  logic [CNTR_WIDTH-1:0]      cfg_count,
  input  logic                       trg,
  input  logic                       halt,
  output logic [GATE_DESC_WIDTH-1:0] m_axis_tdata,
  output logic                       m_axis_tvalid,
  input  logic                       m_axis_tready,
  output logic                       busy,
  output logic [CNTR_WIDTH-1:0]      sts_count
);
  gate_state_t state, state_nxt;
  logic [31:0] on_r, off_r, per_r, step_r, poff_r;
  logic [CNTR_WIDTH-1:0] count_r, cnt, cnt_inc;
  logic trg_rise, hs, start, last;
  axis_gate_sequencer_edge_detector u_trg (
    .aclk    (aclk),
    .aresetn (aresetn),
    .sig     (trg),
    .rise    (trg_rise)
  );
  assign cnt_inc = cnt + CNTR_WIDTH'(1);
  assign hs = m_axis_tvalid & m_axis_tready;
  assign start = (state == IDLE) & trg_rise & ~halt;
  assign last = hs & (((count_r != '0) & (cnt_inc == count_r)) | halt);
  always_comb begin
    state_nxt = state;
    state_nxt = (state == IDLE) ? (start ? SEND : IDLE) : (last ? IDLE : SEND);
  end
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) begin
      state <= IDLE;
      on_r <= '0;
      off_r <= '0;
      per_r <= '0;
      step_r <= '0;
      poff_r <= '0;
      count_r <= '0;
      cnt <= '0;
    end else begin
      state <= state_nxt;
      if (start) begin
        on_r <= cfg_on;
        off_r <= cfg_off;
        per_r <= cfg_period;
        step_r <= cfg_step;
        poff_r <= cfg_poff;
        count_r <= cfg_count;
        cnt <= '0;
      end else if (hs) begin
        cnt <= cnt_inc;
        poff_r <= poff_r + step_r;
      end
    end
  assign m_axis_tvalid = (state == SEND);
  assign busy = (state == SEND);
  assign m_axis_tdata = gate_desc(on_r, off_r, per_r, poff_r);
  assign sts_count = cnt;
endmodule

// File: tb/tb_axis_gate_sequencer.sv
// tb_axis_gate_sequencer: directed self-checking bench for axis_gate_sequencer
module tb_axis_gate_sequencer;
  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  logic [31:0] cfg_on = '0, cfg_off = '0, cfg_period = '0, cfg_poff = '0, cfg_step = '0;
  logic [31:0] cfg_count = '0;
  logic trg = 1'b0, halt = 1'b0, m_axis_tready = 1'b0;
  logic [127:0] m_axis_tdata;
  logic m_axis_tvalid, busy;
  logic [31:0] sts_count;
  logic [127:0] beats [16];
  int checks = 0, failures = 0;
  axis_gate_sequencer #(.CNTR_WIDTH(32)) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .cfg_on        (cfg_on),
    .cfg_off       (cfg_off),
    .cfg_period    (cfg_period),
    .cfg_poff      (cfg_poff),
    .cfg_step      (cfg_step),
    .cfg_count     (cfg_count),
    .trg           (trg),
    .halt          (halt),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .busy          (busy),
    .sts_count     (sts_count)
  );
  always #5 aclk = ~aclk;
  task automatic set_cfg(input logic [31:0] p, input logic [31:0] s, input logic [31:0] c);
    cfg_on = 32'd10;
    cfg_off = 32'd20;
    cfg_period = 32'd100;
    cfg_poff = p;
    cfg_step = s;
    cfg_count = c;
  endtask
  task automatic pulse_trg();
    trg = 1'b1;
    @(negedge aclk);
    trg = 1'b0;
    @(negedge aclk);
  endtask
  task automatic collect(input bit toggle, input int budget, output int n, output int unstable,
                         output int first_c, output int last_c, output int end_c);
    logic [127:0] held;
    bit pend;
    n = 0; unstable = 0; pend = 0; first_c = -1; last_c = -1; end_c = -1; held = '0;
    for (int i = 0; i < 16; i++) beats[i] = '0;
    for (int c = 0; c < budget; c++) begin
      m_axis_tready = toggle ? (c % 3 == 2) : 1'b1;
      #1;
      if (pend && (m_axis_tvalid !== 1'b1 || m_axis_tdata !== held)) unstable++;
      if (m_axis_tvalid && m_axis_tready) begin
        if (n < 16) beats[n] = m_axis_tdata;
        if (n == 0) first_c = c;
        last_c = c;
        n++;
        pend = 0;
      end else if (m_axis_tvalid) begin
        pend = 1;
        held = m_axis_tdata;
      end else if (n > 0 && !busy) begin
        end_c = c;
        break;
      end
      @(negedge aclk);
    end
    m_axis_tready = 1'b0;
  endtask
  task automatic test_reset();
    #2;
    checks++; if (m_axis_tvalid !== 1'b0) begin failures++; $display("FAIL reset_tvalid got=%b exp=0", m_axis_tvalid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (sts_count !== 32'd0) begin failures++; $display("FAIL reset_sts got=%0d exp=0", sts_count); end
    checks++; if (m_axis_tdata !== 128'd0) begin failures++; $display("FAIL reset_tdata got=%h exp=0", m_axis_tdata); end
    repeat (3) @(negedge aclk);
    aresetn = 1'b1;
    repeat (2) @(negedge aclk);
  endtask
  task automatic test_basic();
    int n, u, f, l, e;
    set_cfg(32'd0, 32'd5, 32'd3);
    trg = 1'b1;
    @(negedge aclk);
    #1;
    checks++; if (m_axis_tvalid !== 1'b0) begin failures++; $display("FAIL basic_latency1 got=%b exp=0", m_axis_tvalid); end
    @(negedge aclk);
    trg = 1'b0;
    #1;
    checks++; if (m_axis_tvalid !== 1'b1 || busy !== 1'b1) begin failures++; $display("FAIL basic_latency2 got=%b%b exp=11", m_axis_tvalid, busy); end
    collect(1'b0, 40, n, u, f, l, e);
    checks++; if (n !== 3) begin failures++; $display("FAIL basic_beats got=%0d exp=3", n); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (beats[i][127:96] !== 32'(i * 5)) begin failures++; $display("FAIL basic_poff%0d got=%0d exp=%0d", i, beats[i][127:96], i * 5); end
      checks++; if (beats[i][95:0] !== {32'd100, 32'd20, 32'd10}) begin failures++; $display("FAIL basic_fields%0d got=%h exp=%h", i, beats[i][95:0], {32'd100, 32'd20, 32'd10}); end
    end
    checks++; if (l - f !== 2) begin failures++; $display("FAIL basic_b2b got=%0d exp=2", l - f); end
    checks++; if (e !== l + 1) begin failures++; $display("FAIL basic_busy_fall got=%0d exp=%0d", e, l + 1); end
    checks++; if (sts_count !== 32'd3) begin failures++; $display("FAIL basic_sts got=%0d exp=3", sts_count); end
  endtask
  task automatic test_backpressure();
    int n, u, f, l, e;
    set_cfg(32'd0, 32'd5, 32'd3);
    pulse_trg();
    collect(1'b1, 60, n, u, f, l, e);
    checks++; if (n !== 3) begin failures++; $display("FAIL bp_beats got=%0d exp=3", n); end
    checks++; if (u !== 0) begin failures++; $display("FAIL bp_stable got=%0d exp=0", u); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (beats[i][127:96] !== 32'(i * 5)) begin failures++; $display("FAIL bp_poff%0d got=%0d exp=%0d", i, beats[i][127:96], i * 5); end
    end
    checks++; if (sts_count !== 32'd3) begin failures++; $display("FAIL bp_sts got=%0d exp=3", sts_count); end
  endtask
  task automatic test_wrap();
    int n, u, f, l, e;
    set_cfg(32'hFFFF_FFFE, 32'd3, 32'd2);
    pulse_trg();
    collect(1'b0, 40, n, u, f, l, e);
    checks++; if (n !== 2) begin failures++; $display("FAIL wrap_beats got=%0d exp=2", n); end
    checks++; if (beats[0][127:96] !== 32'hFFFF_FFFE) begin failures++; $display("FAIL wrap_poff0 got=%h exp=fffffffe", beats[0][127:96]); end
    checks++; if (beats[1][127:96] !== 32'h0000_0001) begin failures++; $display("FAIL wrap_poff1 got=%h exp=00000001", beats[1][127:96]); end
  endtask
  task automatic test_halt();
    set_cfg(32'd1000, 32'd3, 32'd0);
    pulse_trg();
    m_axis_tready = 1'b1;
    repeat (7) @(negedge aclk);
    halt = 1'b1;
    #1;
    checks++; if (m_axis_tvalid !== 1'b1 || sts_count !== 32'd7) begin failures++; $display("FAIL halt_pre got=%b/%0d exp=1/7", m_axis_tvalid, sts_count); end
    checks++; if (m_axis_tdata[127:96] !== 32'd1021) begin failures++; $display("FAIL halt_poff got=%0d exp=1021", m_axis_tdata[127:96]); end
    @(negedge aclk);
    halt = 1'b0;
    m_axis_tready = 1'b0;
    #1;
    checks++; if (m_axis_tvalid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL halt_stop got=%b%b exp=00", m_axis_tvalid, busy); end
    checks++; if (sts_count !== 32'd8) begin failures++; $display("FAIL halt_sts got=%0d exp=8", sts_count); end
    pulse_trg();
    halt = 1'b1;
    repeat (3) @(negedge aclk);
    #1;
    checks++; if (m_axis_tvalid !== 1'b1 || sts_count !== 32'd0) begin failures++; $display("FAIL halt_stall got=%b/%0d exp=1/0", m_axis_tvalid, sts_count); end
    m_axis_tready = 1'b1;
    @(negedge aclk);
    m_axis_tready = 1'b0;
    halt = 1'b0;
    #1;
    checks++; if (m_axis_tvalid !== 1'b0 || sts_count !== 32'd1) begin failures++; $display("FAIL halt_stall_end got=%b/%0d exp=0/1", m_axis_tvalid, sts_count); end
    halt = 1'b1;
    pulse_trg();
    repeat (2) @(negedge aclk);
    halt = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || sts_count !== 32'd1) begin failures++; $display("FAIL halt_idle_block got=%b/%0d exp=0/1", busy, sts_count); end
  endtask
  task automatic test_cfg_during_send();
    int n, u, f, l, e;
    set_cfg(32'd0, 32'd5, 32'd4);
    pulse_trg();
    cfg_step = 32'd100;
    trg = 1'b1;
    collect(1'b0, 40, n, u, f, l, e);
    checks++; if (n !== 4) begin failures++; $display("FAIL mid_beats got=%0d exp=4", n); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (beats[i][127:96] !== 32'(i * 5)) begin failures++; $display("FAIL mid_poff%0d got=%0d exp=%0d", i, beats[i][127:96], i * 5); end
    end
    repeat (3) @(negedge aclk);
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mid_no_queue got=%b exp=0", busy); end
    trg = 1'b0;
    @(negedge aclk);
    pulse_trg();
    #1;
    checks++; if (m_axis_tvalid !== 1'b1 || sts_count !== 32'd0) begin failures++; $display("FAIL restart got=%b/%0d exp=1/0", m_axis_tvalid, sts_count); end
    collect(1'b0, 40, n, u, f, l, e);
    checks++; if (n !== 4) begin failures++; $display("FAIL restart_beats got=%0d exp=4", n); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (beats[i][127:96] !== 32'(i * 100)) begin failures++; $display("FAIL restart_poff%0d got=%0d exp=%0d", i, beats[i][127:96], i * 100); end
    end
    checks++; if (sts_count !== 32'd4) begin failures++; $display("FAIL restart_sts got=%0d exp=4", sts_count); end
  endtask
  task automatic test_async_reset();
    set_cfg(32'd7, 32'd1, 32'd0);
    pulse_trg();
    m_axis_tready = 1'b1;
    repeat (2) @(negedge aclk);
    m_axis_tready = 1'b0;
    #1;
    checks++; if (m_axis_tvalid !== 1'b1 || sts_count !== 32'd2) begin failures++; $display("FAIL ares_pre got=%b/%0d exp=1/2", m_axis_tvalid, sts_count); end
    #1;
    aresetn = 1'b0;
    #1;
    checks++; if (m_axis_tvalid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL ares_ctl got=%b%b exp=00", m_axis_tvalid, busy); end
    checks++; if (sts_count !== 32'd0 || m_axis_tdata !== 128'd0) begin failures++; $display("FAIL ares_data got=%0d/%h exp=0/0", sts_count, m_axis_tdata); end
    trg = 1'b1;
    @(negedge aclk);
    aresetn = 1'b1;
    repeat (4) @(negedge aclk);
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL ares_trg_held got=%b exp=0", busy); end
    trg = 1'b0;
    @(negedge aclk);
    pulse_trg();
    #1;
    checks++; if (m_axis_tvalid !== 1'b1) begin failures++; $display("FAIL ares_retrigger got=%b exp=1", m_axis_tvalid); end
    halt = 1'b1;
    m_axis_tready = 1'b1;
    @(negedge aclk);
    halt = 1'b0;
    m_axis_tready = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || sts_count !== 32'd1) begin failures++; $display("FAIL ares_end got=%b/%0d exp=0/1", busy, sts_count); end
  endtask
  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_wrap();
    test_halt();
    test_cfg_during_send();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
